// File: rtl/scanline_pingpong_ram_if.sv
// Bus bundle for scanline_pingpong_ram: two write ports, two read ports and
// the bank-swap control. master drives requests, slave is the RAM.
interface scanline_pingpong_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              wr_enA;
  logic [ADDR_W-1:0] wr_addrA;
  logic [DATA_W-1:0] wr_dataA;
  logic              wr_enB;
  logic [ADDR_W-1:0] wr_addrB;
  logic [DATA_W-1:0] wr_dataB;
  logic              rd_enA;
  logic [ADDR_W-1:0] rd_addrA;
  logic [DATA_W-1:0] rd_dataA;
  logic              rd_hitA;
  logic              rd_enB;
  logic [ADDR_W-1:0] rd_addrB;
  logic [DATA_W-1:0] rd_dataB;
  logic              rd_hitB;
  logic              swap;
  logic              swap_done;
  logic              front_sel;
  logic              back_full;

  modport master (
    output wr_enA, wr_addrA, wr_dataA, wr_enB, wr_addrB, wr_dataB,
    output rd_enA, rd_addrA, rd_enB, rd_addrB, swap,
    input  rd_dataA, rd_hitA, rd_dataB, rd_hitB, swap_done, front_sel, back_full
  );

  modport slave (
    input  wr_enA, wr_addrA, wr_dataA, wr_enB, wr_addrB, wr_dataB,
    input  rd_enA, rd_addrA, rd_enB, rd_addrB, swap,
    output rd_dataA, rd_hitA, rd_dataB, rd_hitB, swap_done, front_sel, back_full
  );
endinterface

// File: rtl/scanline_pingpong_ram.sv
// Double-buffered scanline store: writes fill the back bank, registered reads
// scan the front bank, and a swap exchanges them while invalidating the new back.
module scanline_pingpong_ram #(
  parameter int              DATA_W = 8,
  parameter int              DEPTH  = 20,
  parameter int              ADDR_W = 5,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input logic                   clk,
  input logic                   reset,
  scanline_pingpong_ram_if.slave bus
);

  localparam int unsigned DEPTH_U = DEPTH;

  logic [DATA_W-1:0] mem   [2][DEPTH];
  logic [DEPTH-1:0]  valid [2];

  logic              frontSel;
  logic              backSel;
  logic [DATA_W-1:0] rdDataA, rdDataB;
  logic              rdHitA, rdHitB;
  logic              swapDone;
  logic              backFull;

  logic              wrOkA, wrOkB;
  logic              hitNextA, hitNextB;
  logic [DATA_W-1:0] dataNextA, dataNextB;

  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH_U;
  endfunction

  assign backSel = ~frontSel;
  assign wrOkA   = bus.wr_enA && inRange(bus.wr_addrA);
  assign wrOkB   = bus.wr_enB && inRange(bus.wr_addrB);

  always_comb begin
    hitNextA  = 1'b0;
    hitNextB  = 1'b0;
    dataNextA = FILL;
    dataNextB = FILL;
    if (inRange(bus.rd_addrA) && valid[frontSel][bus.rd_addrA]) begin
      hitNextA  = 1'b1;
      dataNextA = mem[frontSel][bus.rd_addrA];
    end
    if (inRange(bus.rd_addrB) && valid[frontSel][bus.rd_addrB]) begin
      hitNextB  = 1'b1;
      dataNextB = mem[frontSel][bus.rd_addrB];
    end
  end

  // Payload is never reset; the valid bits mask whatever is left in it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wrOkA) mem[backSel][bus.wr_addrA] <= bus.wr_dataA;
      if (wrOkB) mem[backSel][bus.wr_addrB] <= bus.wr_dataB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frontSel <= 1'b0;
      valid[0] <= '0;
      valid[1] <= '0;
      rdDataA  <= FILL;
      rdDataB  <= FILL;
      rdHitA   <= 1'b0;
      rdHitB   <= 1'b0;
      swapDone <= 1'b0;
      backFull <= 1'b0;
    end else begin
      backFull <= &valid[backSel];
      swapDone <= bus.swap;
      if (bus.rd_enA) begin
        rdDataA <= dataNextA;
        rdHitA  <= hitNextA;
      end
      if (bus.rd_enB) begin
        rdDataB <= dataNextB;
        rdHitB  <= hitNextB;
      end
      if (wrOkA) valid[backSel][bus.wr_addrA] <= 1'b1;
      if (wrOkB) valid[backSel][bus.wr_addrB] <= 1'b1;
      // Writes land in the old back bank, which is the one that becomes front.
      if (bus.swap) begin
        frontSel        <= ~frontSel;
        valid[frontSel] <= '0;
      end
    end
  end

  assign bus.rd_dataA  = rdDataA;
  assign bus.rd_hitA   = rdHitA;
  assign bus.rd_dataB  = rdDataB;
  assign bus.rd_hitB   = rdHitB;
  assign bus.swap_done = swapDone;
  assign bus.front_sel = frontSel;
  assign bus.back_full = backFull;

endmodule

// File: tb/tb_scanline_pingpong_ram.sv
// Randomised self-checking bench for scanline_pingpong_ram against a
// front/back array model of the double buffer.
module tb_scanline_pingpong_ram;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 20;
  localparam int ADDR_W = 5;
  localparam logic [DATA_W-1:0] FILL = '0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scanline_pingpong_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  scanline_pingpong_ram #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL(FILL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model: the front and back lines are separate arrays that trade places on swap.
  logic [DATA_W-1:0] frontD [DEPTH];
  logic [DATA_W-1:0] backD  [DEPTH];
  bit                frontV [DEPTH];
  bit                backV  [DEPTH];
  bit                mFront, mHitA, mHitB, mSwapDone, mBackFull;
  logic [DATA_W-1:0] mRdA, mRdB;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelRead(input int a, output logic [DATA_W-1:0] d, output bit h);
    if (a < DEPTH && frontV[a]) begin
      d = frontD[a];
      h = 1'b1;
    end else begin
      d = FILL;
      h = 1'b0;
    end
  endtask

  task automatic modelEdge();
    bit full;
    if (reset) begin
      mFront = 1'b0; mRdA = FILL; mRdB = FILL; mHitA = 1'b0; mHitB = 1'b0;
      mSwapDone = 1'b0; mBackFull = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        frontV[i] = 1'b0;
        backV[i]  = 1'b0;
      end
    end else begin
      full = 1'b1;
      for (int i = 0; i < DEPTH; i++) full &= backV[i];
      mBackFull = full;
      mSwapDone = bus.swap;
      if (bus.rd_enA) modelRead(int'(bus.rd_addrA), mRdA, mHitA);
      if (bus.rd_enB) modelRead(int'(bus.rd_addrB), mRdB, mHitB);
      if (bus.wr_enA && int'(bus.wr_addrA) < DEPTH) begin
        backD[bus.wr_addrA] = bus.wr_dataA;
        backV[bus.wr_addrA] = 1'b1;
      end
      if (bus.wr_enB && int'(bus.wr_addrB) < DEPTH) begin
        backD[bus.wr_addrB] = bus.wr_dataB;
        backV[bus.wr_addrB] = 1'b1;
      end
      if (bus.swap) begin
        for (int i = 0; i < DEPTH; i++) begin
          logic [DATA_W-1:0] td;
          td = frontD[i]; frontD[i] = backD[i]; backD[i] = td;
          frontV[i] = backV[i];
          backV[i]  = 1'b0;
        end
        mFront = ~mFront;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    checkVal({tag, ".rdDataA"}, 32'(bus.rd_dataA), 32'(mRdA));
    checkVal({tag, ".rdHitA"}, 32'(bus.rd_hitA), 32'(mHitA));
    checkVal({tag, ".rdDataB"}, 32'(bus.rd_dataB), 32'(mRdB));
    checkVal({tag, ".rdHitB"}, 32'(bus.rd_hitB), 32'(mHitB));
    checkVal({tag, ".swapDone"}, 32'(bus.swap_done), 32'(mSwapDone));
    checkVal({tag, ".frontSel"}, 32'(bus.front_sel), 32'(mFront));
    checkVal({tag, ".backFull"}, 32'(bus.back_full), 32'(mBackFull));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    compareAll(tag);
  endtask

  task automatic idle();
    bus.wr_enA = 1'b0; bus.wr_addrA = '0; bus.wr_dataA = '0;
    bus.wr_enB = 1'b0; bus.wr_addrB = '0; bus.wr_dataB = '0;
    bus.rd_enA = 1'b0; bus.rd_addrA = '0;
    bus.rd_enB = 1'b0; bus.rd_addrB = '0;
    bus.swap   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    cyc("reset0");
    cyc("reset1");
    reset = 1'b0;

    // Empty front bank reads FILL on every address.
    for (int k = 0; k < DEPTH; k++) begin
      bus.rd_enA = 1'b1; bus.rd_addrA = ADDR_W'(k);
      bus.rd_enB = 1'b1; bus.rd_addrB = ADDR_W'(DEPTH - 1 - k);
      cyc("emptyRead");
      checkVal("emptyHitA", 32'(bus.rd_hitA), 32'd0);
      checkVal("emptyDataB", 32'(bus.rd_dataB), 32'(FILL));
    end
    idle();

    // Fill the whole back bank, alternating ports.
    for (int k = 0; k < DEPTH; k++) begin
      idle();
      if (k % 2 == 0) begin
        bus.wr_enA = 1'b1; bus.wr_addrA = ADDR_W'(k); bus.wr_dataA = 8'hA0 + 8'(k);
      end else begin
        bus.wr_enB = 1'b1; bus.wr_addrB = ADDR_W'(k); bus.wr_dataB = 8'hA0 + 8'(k);
      end
      cyc("fill");
    end
    idle();
    cyc("fullWait");
    checkVal("backFullSet", 32'(bus.back_full), 32'd1);
    bus.swap = 1'b1;
    cyc("swap1");
    checkVal("swapDonePulse", 32'(bus.swap_done), 32'd1);
    checkVal("frontSelAfterSwap", 32'(bus.front_sel), 32'd1);
    idle();
    bus.rd_enA = 1'b1; bus.rd_addrA = 5'd7;
    cyc("readA7");
    checkVal("swapDoneDrop", 32'(bus.swap_done), 32'd0);
    checkVal("readA7data", 32'(bus.rd_dataA), 32'hA7);
    checkVal("readA7hit", 32'(bus.rd_hitA), 32'd1);
    checkVal("backFullDrop", 32'(bus.back_full), 32'd0);

    // Same-address collision: port B wins.
    idle();
    bus.wr_enA = 1'b1; bus.wr_addrA = 5'd3; bus.wr_dataA = 8'h11;
    bus.wr_enB = 1'b1; bus.wr_addrB = 5'd3; bus.wr_dataB = 8'h22;
    cyc("collide");
    idle(); bus.swap = 1'b1;
    cyc("swap2");
    idle(); bus.rd_enB = 1'b1; bus.rd_addrB = 5'd3;
    cyc("readCollide");
    checkVal("collideData", 32'(bus.rd_dataB), 32'h22);
    checkVal("collideHit", 32'(bus.rd_hitB), 32'd1);

    // Write, read and swap in one cycle.
    idle();
    bus.swap = 1'b1;
    bus.wr_enA = 1'b1; bus.wr_addrA = 5'd19; bus.wr_dataA = 8'h5C;
    bus.rd_enA = 1'b1; bus.rd_addrA = 5'd19;
    cyc("swapWriteRead");
    checkVal("oldFrontHit", 32'(bus.rd_hitA), 32'd0);
    idle(); bus.rd_enA = 1'b1; bus.rd_addrA = 5'd19;
    cyc("readNewFront");
    checkVal("newFrontData", 32'(bus.rd_dataA), 32'h5C);
    checkVal("newFrontHit", 32'(bus.rd_hitA), 32'd1);
    bus.rd_addrA = 5'd5;
    cyc("unwritten");
    checkVal("unwrittenHit", 32'(bus.rd_hitA), 32'd0);

    // Out-of-range addresses.
    idle();
    bus.wr_enA = 1'b1; bus.wr_addrA = 5'd20; bus.wr_dataA = 8'hEE;
    bus.wr_enB = 1'b1; bus.wr_addrB = 5'd31; bus.wr_dataB = 8'hDD;
    cyc("oorWrite");
    idle(); bus.swap = 1'b1;
    cyc("swap4");
    idle();
    bus.rd_enA = 1'b1; bus.rd_addrA = 5'd20;
    bus.rd_enB = 1'b1; bus.rd_addrB = 5'd31;
    cyc("oorRead");
    checkVal("oor20data", 32'(bus.rd_dataA), 32'(FILL));
    checkVal("oor31hit", 32'(bus.rd_hitB), 32'd0);

    // Reset during a fill with swap asserted.
    idle();
    for (int k = 0; k < 6; k++) begin
      bus.wr_enA = 1'b1; bus.wr_addrA = ADDR_W'(k); bus.wr_dataA = 8'(k + 1);
      cyc("preReset");
    end
    reset = 1'b1; bus.swap = 1'b1;
    cyc("resetSwap");
    checkVal("rstFront", 32'(bus.front_sel), 32'd0);
    checkVal("rstSwapDone", 32'(bus.swap_done), 32'd0);
    checkVal("rstHitA", 32'(bus.rd_hitA), 32'd0);
    reset = 1'b0; idle();
    cyc("postReset");
    checkVal("postRstSwapDone", 32'(bus.swap_done), 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 199) == 0);
      bus.wr_enA    = ($urandom_range(0, 9) < 8);
      bus.wr_addrA  = ADDR_W'($urandom_range(0, 23));
      bus.wr_dataA  = DATA_W'($urandom);
      bus.wr_enB    = ($urandom_range(0, 9) < 8);
      bus.wr_addrB  = ADDR_W'($urandom_range(0, 23));
      bus.wr_dataB  = DATA_W'($urandom);
      bus.rd_enA    = ($urandom_range(0, 3) != 0);
      bus.rd_addrA  = ADDR_W'($urandom_range(0, 31));
      bus.rd_enB    = ($urandom_range(0, 3) != 0);
      bus.rd_addrB  = ADDR_W'($urandom_range(0, 31));
      bus.swap      = (n % 400 < 100) ? ($urandom_range(0, 2) == 0)
                                      : ($urandom_range(0, 39) == 0);
      cyc("rand");
    end
    reset = 1'b0; idle();
    cyc("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
